// File: rtl/dbus_narrow_bridge_pkg.sv
// Shared types and helpers for the 64-bit to 32-bit data-bus bridge.
// Holds the upstream request/response structs, the FSM states and the half-offset constants.
package dbus_narrow_bridge_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } bridge_state_t;

  localparam logic [2:0] HALF_LO = 3'b000;
  localparam logic [2:0] HALF_HI = 3'b100;

  function automatic logic [3:0] msize_bytes(input msize_t size);
    case (size)
      MSIZE1:  msize_bytes = 4'd1;
      MSIZE2:  msize_bytes = 4'd2;
      MSIZE4:  msize_bytes = 4'd4;
      MSIZE8:  msize_bytes = 4'd8;
      default: msize_bytes = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/dbus_beat_plan.sv
// Combinational beat planner: decides which 32-bit halves an access touches
// and whether the address is naturally aligned for its size.
module dbus_beat_plan
  import dbus_narrow_bridge_pkg::*;
(
  input  logic [2:0] addr_low,
  input  msize_t     size,
  output logic       need_lo,
  output logic       need_hi,
  output logic       misaligned
);

  logic [3:0] bytes;
  logic [4:0] end_off;
  logic [2:0] mask;

  // An access spills into the upper half when its last byte lies past offset 3.
  always_comb begin
    bytes      = msize_bytes(size);
    end_off    = {2'b00, addr_low} + {1'b0, bytes};
    mask       = bytes[2:0] - 3'd1;
    need_lo    = ~addr_low[2];
    need_hi    = addr_low[2] | (end_off > 5'd4);
    misaligned = (addr_low & mask) != 3'b000;
  end

endmodule

// File: rtl/dbus_narrow_bridge.sv
// Serves 64-bit data-bus requests through a 32-bit single-outstanding memory port.
// Define DBUS_NARROW_BRIDGE_MISALIGN_CHECK_EN to reject misaligned accesses with a misalign pulse.
module dbus_narrow_bridge
  import dbus_narrow_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        mreq_valid,
  output logic [63:0] mreq_addr,
  output logic        mreq_write,
  output logic [3:0]  mreq_strobe,
  output logic [31:0] mreq_wdata,
  input  logic        mresp_ready,
  input  logic [31:0] mresp_rdata,
  output logic        misalign
);

  bridge_state_t state, state_next;
  logic [60:0]   addr_q;
  logic [7:0]    strobe_q;
  logic [63:0]   data_q;
  logic          need_hi_q;
  logic [63:0]   hold_q;
  logic          addr_ok_q, data_ok_q, misalign_q;

  logic          need_lo, need_hi, misaligned, reject;
  logic          accept, beat_done;
  logic [60:0]   src_addr;
  logic [7:0]    src_strobe;
  logic [63:0]   src_data;
  logic          beat_valid_n, beat_write_n;
  logic [63:0]   beat_addr_n;
  logic [3:0]    beat_strobe_n;
  logic [31:0]   beat_wdata_n;

  dbus_beat_plan u_plan (
    .addr_low   (dreq.addr[2:0]),
    .size       (dreq.size),
    .need_lo    (need_lo),
    .need_hi    (need_hi),
    .misaligned (misaligned)
  );

`ifdef DBUS_NARROW_BRIDGE_MISALIGN_CHECK_EN
  assign reject = misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign reject = 1'b0;
`endif

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    beat_done  = mreq_valid & mresp_ready;
    case (state)
      IDLE: if (dreq.valid) begin
        accept = 1'b1;
        if (reject)       state_next = RESP;
        else if (need_lo) state_next = LO;
        else              state_next = HI;
      end
      LO:   if (beat_done) state_next = need_hi_q ? HI : RESP;
      HI:   if (beat_done) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat outputs are computed for the upcoming state so they can be registered;
  // on the accept edge the fields come straight from the request being captured.
  always_comb begin
    src_addr      = accept ? dreq.addr[63:3] : addr_q;
    src_strobe    = accept ? dreq.strobe     : strobe_q;
    src_data      = accept ? dreq.data       : data_q;
    beat_valid_n  = 1'b0;
    beat_write_n  = 1'b0;
    beat_addr_n   = '0;
    beat_strobe_n = '0;
    beat_wdata_n  = '0;
    if (state_next == LO) begin
      beat_valid_n  = 1'b1;
      beat_write_n  = |src_strobe;
      beat_addr_n   = {src_addr, HALF_LO};
      beat_strobe_n = src_strobe[3:0];
      beat_wdata_n  = src_data[31:0];
    end else if (state_next == HI) begin
      beat_valid_n  = 1'b1;
      beat_write_n  = |src_strobe;
      beat_addr_n   = {src_addr, HALF_HI};
      beat_strobe_n = src_strobe[7:4];
      beat_wdata_n  = src_data[63:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      strobe_q    <= '0;
      data_q      <= '0;
      need_hi_q   <= 1'b0;
      hold_q      <= '0;
      addr_ok_q   <= 1'b0;
      data_ok_q   <= 1'b0;
      misalign_q  <= 1'b0;
      mreq_valid  <= 1'b0;
      mreq_write  <= 1'b0;
      mreq_addr   <= '0;
      mreq_strobe <= '0;
      mreq_wdata  <= '0;
    end else begin
      state       <= state_next;
      addr_ok_q   <= accept;
      data_ok_q   <= (state_next == RESP);
      misalign_q  <= accept & reject;
      mreq_valid  <= beat_valid_n;
      mreq_write  <= beat_write_n;
      mreq_addr   <= beat_addr_n;
      mreq_strobe <= beat_strobe_n;
      mreq_wdata  <= beat_wdata_n;
      if (accept) begin
        addr_q    <= dreq.addr[63:3];
        strobe_q  <= dreq.strobe;
        data_q    <= dreq.data;
        need_hi_q <= need_hi;
        hold_q    <= '0;
      end else if (beat_done && (strobe_q == 8'h00)) begin
        if (state == LO)      hold_q[31:0]  <= mresp_rdata;
        else if (state == HI) hold_q[63:32] <= mresp_rdata;
      end
    end
  end

  assign dresp.addr_ok = addr_ok_q;
  assign dresp.data_ok = data_ok_q;
  assign dresp.data    = hold_q;
  assign misalign      = misalign_q;

endmodule

// File: doc/dbus_narrow_bridge.md
# dbus_narrow_bridge

Downstream of the data-memory access stage: accepts that stage's 64-bit `dbus_req_t` and returns `dbus_resp_t`. It serves each request through a 32-bit single-outstanding memory port, issuing one or two beats. Read beats are reassembled into lane-aligned 64-bit data so the upstream byte/half/word extraction by `addr[2:0]` works unchanged. Write strobes and data are split per 32-bit half.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `dreq` in `dbus_req_t`: fields valid, addr[63:0], size (MSIZE1/2/4/8), strobe[7:0] (0 = read), data[63:0].
- `dresp` out `dbus_resp_t`: addr_ok, data_ok, data[63:0].
- `mreq_valid` out 1: narrow beat request.
- `mreq_addr` out 64: beat address, bits[1:0] = 0, bit 2 selects the half.
- `mreq_write` out 1: 1 = write beat.
- `mreq_strobe` out 4: byte enables for the beat.
- `mreq_wdata` out 32: write data for the beat.
- `mresp_ready` in 1: beat completes at a rising edge where `mreq_valid & mresp_ready`.
- `mresp_rdata` in 32: read data, valid while `mresp_ready` is high.
- `misalign` out 1: one-cycle error pulse; constant 0 unless the macro is enabled.

## Operation
- States: IDLE, LO, HI, RESP.
- Accept: in IDLE with `dreq.valid`=1, capture addr/size/strobe/data. Compute touched halves, with bytes = 1/2/4/8 from size:
  - lower half if addr[2]=0;
  - upper half if addr[2]=1, or if addr[2:0] + bytes > 4.
- Transitions:
  - IDLE → LO if the lower half is touched, else IDLE → HI.
  - LO → HI on beat completion if the upper half is touched, else LO → RESP.
  - HI → RESP on beat completion.
  - RESP → IDLE unconditionally.
- Beat outputs:
  - LO: `mreq_addr` = {addr[63:3], 3'b000}, strobe = strobe[3:0], wdata = data[31:0].
  - HI: `mreq_addr` = {addr[63:3], 3'b100}, strobe = strobe[7:4], wdata = data[63:32].
  - `mreq_write` = (strobe != 0).
- Read assembly: the LO beat fills the data hold register [31:0], the HI beat fills [63:32]. Halves not touched read as 0. The hold register clears on accept.
- `dresp.addr_ok` is a one-cycle pulse in the first cycle after accept.
- `dresp.data_ok` is high only in RESP.
- `dresp.data` shows the hold register. It stays stable from RESP until the next accept.
- Writes also complete with `data_ok`. `dresp.data` is then the cleared hold register (0).
- No request is accepted in RESP. A request still valid upon return to IDLE is treated as new; upstream must drop valid at the edge where it sees `data_ok`.
- Request fields are sampled only at accept; later changes are ignored.

## Timing
- Reset: state IDLE; `mreq_valid`, `mreq_write`, `mreq_strobe`, `mreq_wdata`, `mreq_addr` = 0; `dresp` all 0; `misalign` = 0; hold register = 0.
- Reset asserted mid-operation aborts the transaction immediately: `mreq_valid` falls asynchronously and no `data_ok` is issued.
- Accept edge T; zero-wait memory:
  - one beat: `mreq_valid` in T+1, `data_ok` in T+2;
  - two beats: `mreq_valid` in T+1 and T+2, `data_ok` in T+3.
- Each wait cycle (`mresp_ready`=0) adds one cycle.
- `mreq_*` are held constant while `mreq_valid`=1 and not ready.
- All outputs are registered; there is no combinational path from `dreq` or `mresp_*` to outputs.

## Configuration
- `DBUS_NARROW_BRIDGE_MISALIGN_CHECK_EN` defined:
  - At accept, if addr is not a multiple of bytes, go directly IDLE → RESP and issue no beats.
  - `data_ok`=1 with `data`=0, `misalign`=1 in the same cycle.
  - `addr_ok` still pulses in the cycle after accept, i.e. coincident with RESP.
- Undefined: no check; misaligned accesses follow the touched-halves rule and `misalign` is tied 0.

## Structure
- Shared package:
  - `bridge_state_t` enum (IDLE/LO/HI/RESP);
  - `msize_bytes()` function mapping MSIZE to 1/2/4/8;
  - `HALF_LO`/`HALF_HI` address-offset constants.
- One sub-module, `dbus_beat_plan`: purely combinational; from addr[2:0] and size produces need_lo, need_hi and misaligned.

## Test plan
- ld, addr 0x80000008, memory returns 0x11223344 then 0xAABBCCDD, no waits → two beats at 0x..08/0x..0C, `data_ok` at T+3, data = 0xAABBCCDD11223344.
- lw, addr 0x80000004, rdata 0xDEADBEEF, `mresp_ready` low for 2 cycles → single HI beat held stable 3 cycles, data = 0xDEADBEEF00000000.
- sb, addr 0x80000003, strobe 0x08, data[31:24] = 0x5A → one LO write beat, strobe 4'b1000, wdata[31:24] = 0x5A, `data_ok` at T+2.
- sh, addr 0x80000006, strobe 0xC0 → one HI beat, strobe 4'b1100; `dreq.valid` held after `data_ok` → new accept in the following IDLE cycle.
- Reset asserted while the LO beat is waiting → `mreq_valid` drops the same cycle, no `data_ok`, state IDLE; the next ld completes normally.
- Macro on, lw at addr 0x80000002 → no `mreq_valid`, `data_ok` and `misalign` high together at T+1 with data 0. Macro off → LO beat issued.
